// File: rtl/pbm_rollback_fifo.sv
// Store-and-forward packet buffer: beats are held tentatively until s_tlast, then committed or rolled back.
// Define PBM_STATS_EN to build the drop_count/commit_count statistics counters; otherwise both read 0.
module pbm_rollback_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 64,
  parameter int PKT_CNT_WIDTH = 8,
  parameter int STAT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  input  logic                      s_terror,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic [PKT_CNT_WIDTH-1:0]  pkt_count,
  output logic [$clog2(DEPTH):0]    free_words,
  output logic [STAT_WIDTH-1:0]     drop_count,
  output logic [STAT_WIDTH-1:0]     commit_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_P = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [PKT_CNT_WIDTH-1:0] PKT_ONE = {{(PKT_CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_DISCARD
  } state_t;

  state_t                   state_reg;
  logic [AW:0]              wr_ptr_reg;
  logic [AW:0]              cm_ptr_reg;
  logic [AW:0]              rd_ptr_reg;
  logic [AW:0]              fetch_ptr_reg;
  logic                     err_seen_reg;

  logic [DATA_WIDTH:0]      mem [DEPTH];
  logic [DATA_WIDTH:0]      s1_data_reg;
  logic                     s1_valid_reg;
  logic [DATA_WIDTH:0]      out_data_reg;
  logic                     out_valid_reg;
  logic [PKT_CNT_WIDTH-1:0] pkt_count_reg;
  logic [AW:0]              free_words_reg;

  logic accept;
  logic full;
  logic do_write;
  logic do_commit;
  logic do_drop;
  logic pop;
  logic pop_last;
  logic move_s1;
  logic rd_en;

  // Never back-pressure: overflow is handled by dropping the packet.
  assign s_tready = rst_n;
  assign accept   = s_tvalid & s_tready;
  assign full     = (wr_ptr_reg - rd_ptr_reg) == DEPTH_P;

  always_comb begin
    do_write  = 1'b0;
    do_commit = 1'b0;
    do_drop   = 1'b0;
    if (accept && state_reg != ST_DISCARD) begin
      if (!s_tlast) begin
        if (full) begin
          do_drop = 1'b1;
        end else begin
          do_write = 1'b1;
        end
      end else if (err_seen_reg || s_terror || full) begin
        do_drop = 1'b1;
      end else begin
        do_write  = 1'b1;
        do_commit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      wr_ptr_reg   <= '0;
      cm_ptr_reg   <= '0;
      err_seen_reg <= 1'b0;
    end else if (accept) begin
      case (state_reg)
        ST_DISCARD: begin
          if (s_tlast) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          if (do_drop) begin
            wr_ptr_reg   <= cm_ptr_reg;
            err_seen_reg <= 1'b0;
            state_reg    <= s_tlast ? ST_IDLE : ST_DISCARD;
          end else if (do_commit) begin
            wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
            cm_ptr_reg   <= wr_ptr_reg + PTR_ONE;
            err_seen_reg <= 1'b0;
            state_reg    <= ST_IDLE;
          end else begin
            wr_ptr_reg   <= wr_ptr_reg + PTR_ONE;
            err_seen_reg <= err_seen_reg | s_terror;
            state_reg    <= ST_ACCEPT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg[AW-1:0]] <= {s_tlast, s_tdata};
    end
  end

  // Two-stage egress: RAM read register (s1) feeding the output register.
  // rd_ptr only moves on a handshake, so words still in flight stay protected from overwrite.
  assign pop      = out_valid_reg & m_tready;
  assign pop_last = pop & out_data_reg[DATA_WIDTH];
  assign move_s1  = s1_valid_reg & (~out_valid_reg | m_tready);
  assign rd_en    = (fetch_ptr_reg != cm_ptr_reg) & (~s1_valid_reg | move_s1);

  always_ff @(posedge clk) begin
    if (rd_en) begin
      s1_data_reg <= mem[fetch_ptr_reg[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_ptr_reg  <= '0;
      rd_ptr_reg     <= '0;
      s1_valid_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      pkt_count_reg  <= '0;
      free_words_reg <= DEPTH_P;
    end else begin
      if (rd_en) begin
        fetch_ptr_reg <= fetch_ptr_reg + PTR_ONE;
      end
      s1_valid_reg <= rd_en | (s1_valid_reg & ~move_s1);
      if (move_s1) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= s1_data_reg;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({do_commit, pop_last})
        2'b10:   pkt_count_reg <= pkt_count_reg + PKT_ONE;
        2'b01:   pkt_count_reg <= pkt_count_reg - PKT_ONE;
        default: pkt_count_reg <= pkt_count_reg;
      endcase
      free_words_reg <= DEPTH_P - (cm_ptr_reg - rd_ptr_reg);
    end
  end

  assign m_tvalid   = out_valid_reg;
  assign m_tdata    = out_data_reg[DATA_WIDTH-1:0];
  assign m_tlast    = out_data_reg[DATA_WIDTH];
  assign pkt_count  = pkt_count_reg;
  assign free_words = free_words_reg;

`ifdef PBM_STATS_EN
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

  logic [STAT_WIDTH-1:0] drop_cnt_reg;
  logic [STAT_WIDTH-1:0] commit_cnt_reg;

  // Saturating: a stuck-at-max counter is more useful than one that silently wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg   <= '0;
      commit_cnt_reg <= '0;
    end else begin
      if (do_drop && drop_cnt_reg != '1) begin
        drop_cnt_reg <= drop_cnt_reg + STAT_ONE;
      end
      if (do_commit && commit_cnt_reg != '1) begin
        commit_cnt_reg <= commit_cnt_reg + STAT_ONE;
      end
    end
  end

  assign drop_count   = drop_cnt_reg;
  assign commit_count = commit_cnt_reg;
`else
  assign drop_count   = '0;
  assign commit_count = '0;
`endif

endmodule

// File: doc/pbm_rollback_fifo.md
Name: pbm_rollback_fifo

Overview:
- Parametrised store-and-forward packet buffer with commit and rollback, placed between the gearbox output and the DMA write engine in dma_subsystem.
- Accepts an AXI-Stream-like packet stream. Holds beats tentatively until the last beat, then either commits the packet or rolls the write pointer back.
- Rollback happens on an error flag or on overflow, so bad or partial packets never reach m_*.
- Generalises the single-packet PBM to a configurable width and depth, with multiple queued packets and occupancy/statistics outputs.

Parameters:
DATA_WIDTH, 32, stream data width in bits.
DEPTH, 64, buffer entries; power of two, ≥4.
PKT_CNT_WIDTH, 8, width of pkt_count.
STAT_WIDTH, 16, width of drop_count and commit_count.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
s_tdata  input  DATA_WIDTH  ingress data
s_tvalid  input  1  ingress beat valid
s_tready  output  1  ingress ready
s_tlast  input  1  last beat of packet
s_terror  input  1  packet error flag, sampled on any accepted beat
m_tdata  output  DATA_WIDTH  egress data
m_tvalid  output  1  egress valid
m_tready  input  1  egress ready
m_tlast  output  1  egress last beat
pkt_count  output  PKT_CNT_WIDTH  committed packets held
free_words  output  $clog2(DEPTH)+1  DEPTH minus committed-unread words
drop_count  output  STAT_WIDTH  packets rolled back
commit_count  output  STAT_WIDTH  packets committed

Behaviour:
- Reset values:
  - All outputs are 0, except free_words = DEPTH.
  - All pointers are 0; storage contents are don't-care.
  - Ingress FSM is in IDLE.
- Reset mid-packet or mid-drain discards everything; no partial packet survives.
- Storage: DEPTH × (DATA_WIDTH+1), holding tlast alongside data.
- Pointers: wr_ptr (tentative), cm_ptr (commit) and rd_ptr are each AW+1 bits with a wrap bit, AW = log2(DEPTH).
- Full condition: (wr_ptr − rd_ptr) == DEPTH.
- s_tready is 1 whenever out of reset. The block never back-pressures; it drops instead.
- Accepted beat: s_tvalid & s_tready.
- Ingress FSM:
  - IDLE/ACCEPT, accepted non-last beat, not full: write the beat, wr_ptr+1, err_seen |= s_terror, go to ACCEPT.
  - Accepted non-last beat while full: wr_ptr ← cm_ptr, drop_count+1, go to DISCARD.
  - Accepted last beat with (err_seen | s_terror | full): wr_ptr ← cm_ptr, the beat is not written, drop_count+1, go to IDLE.
  - Accepted last beat, otherwise: write the beat, cm_ptr ← wr_ptr+1, commit_count+1, pkt_count+1, go to IDLE.
  - DISCARD: sink beats without writing until an accepted s_tlast, then go to IDLE. drop_count is not incremented again.
  - err_seen clears on every return to IDLE.
- A single-beat packet (s_tlast on the first beat) follows the last-beat rules directly from IDLE.
- Packets longer than DEPTH beats are always dropped.
- Egress:
  - First-word-fall-through output register fed from storage, reading only while rd_ptr ≠ cm_ptr.
  - m_tvalid rises on the 2nd rising edge after the edge that advanced cm_ptr, provided the output register was empty.
  - Sustains 1 beat/cycle while m_tready stays high.
  - While m_tvalid & !m_tready, m_tdata and m_tlast hold stable.
- pkt_count:
  - Decrements on m_tvalid & m_tready & m_tlast.
  - A simultaneous commit and egress-last leaves it unchanged.
- free_words = DEPTH − (cm_ptr − rd_ptr), updated the cycle after the pointer change. Tentative words are not counted.
- drop_count and commit_count saturate at all-ones and do not wrap.
- All pointer arithmetic is modulo 2^(AW+1).

Optional Feature:
PBM_STATS_EN
- Defined: drop_count and commit_count are live saturating counters as described above.
- Undefined: both ports are tied to 0 and the counter registers are not instantiated. All other behaviour is identical.

Test Plan:
- Good packet: AABBCCDD, 11223344, EEFF0000 (last), m_tready=1 → m_* carries exactly those 3 beats in order with m_tlast on the 3rd; pkt_count pulses 1→0; commit_count=1.
- Error rollback: DEADBEEF, BAD0BAD0 with s_terror=1 on the last beat, then good packet 12345678 (last) → m_* shows only 12345678; drop_count=1; free_words returns to DEPTH.
- Overflow (DEPTH=16): with m_tready=0, send a 10-beat good packet then an 8-beat packet → 2nd dropped, DISCARD sinks beats 7–8, pkt_count=1, free_words=6; release m_tready → only 10 beats emerge.
- Back-pressure: toggle m_tready every cycle during a 4-beat packet → m_tdata stable while stalled; all 4 beats delivered with no duplication.
- Wrap and simultaneity (DEPTH=16): stream 40 three-beat good packets with random m_tready → all 120 beats correct; pkt_count never underflows when commit and egress-last coincide.
- Reset mid-packet: assert rst_n=0 after 2 beats of a 4-beat packet → all outputs reset as specified; the next packet passes intact.
